// File: rtl/z3_slave_engine_pkg.sv
// Zorro III slave engine shared definitions: cycle states,
// default address windows and the burst beat helper.
package z3_slave_engine_pkg;

   // Cycle states; NEXT and ERROR extend the original four-state set.
   typedef enum logic [2:0] {
      Z3_IDLE,
      Z3_START,
      Z3_DATA,
      Z3_END,
      Z3_NEXT,
      Z3_ERROR
   } z3_state_t;

   // Default windows, region 0 in the LSBs.
   localparam logic [95:0] Z3_REGION_BASE_DFLT =
      {24'h8C0000, 24'h880000, 24'h800000, 24'h000000};
   localparam logic [95:0] Z3_REGION_MASK_DFLT =
      {24'hFC0000, 24'hFC0000, 24'hF80000, 24'h800000};

   // Last longword of a 256-byte page: a burst may not cross it.
   localparam logic [5:0] Z3_LAST_LW = 6'h3F;

   // Beat count saturates instead of wrapping.
   function automatic logic [5:0] z3_beat_inc(input logic [5:0] b);
      return (b == 6'h3F) ? b : b + 6'd1;
   endfunction

endpackage

// File: rtl/z3_wait_timer.sv
// Wait-state down-counter and bus-error timeout up-counter.
// Ports: i_clk, i_reset, i_load, i_wait_val, i_run -> o_wait_done, o_timed_out.
module z3_wait_timer #(
   parameter int WAIT_W  = 4,
   parameter int TIMEOUT = 63
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic [WAIT_W-1:0] i_wait_val,
   input  logic              i_run,
   output logic              o_wait_done,
   output logic              o_timed_out
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [WAIT_W-1:0] r_wait;
   logic [TW-1:0]     r_tmo;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wait <= '0;
         r_tmo  <= '0;
      end else if (i_load) begin
         r_wait <= i_wait_val;
         r_tmo  <= '0;
      end else if (i_run) begin
         if (r_wait != '0)
            r_wait <= r_wait - WAIT_W'(1);
         if (!o_timed_out)
            r_tmo <= r_tmo + TW'(1);
      end
   end

   assign o_wait_done = (r_wait == '0);
   // Flags on the DATA cycle whose increment reaches TIMEOUT.
   assign o_timed_out = (r_tmo == TW'(TIMEOUT - 1));

endmodule

// File: rtl/z3_slave_engine.sv
// Zorro III slave cycle engine: region decode, wait states, DTACK, bursts, BERR.
// Ports: i_clk/i_reset, bus inputs (fcs, match, ds_n, cbreq_n, addr), per-region wait/ready -> dtack, cback, berr, region_sel, beat.
module z3_slave_engine
   import z3_slave_engine_pkg::*;
#(
   parameter int                        NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*24-1:0] REGION_BASE = Z3_REGION_BASE_DFLT,
   parameter logic [NUM_REGIONS*24-1:0] REGION_MASK = Z3_REGION_MASK_DFLT,
   parameter int                        WAIT_W      = 4,
   parameter int                        TIMEOUT     = 63,
   parameter bit                        BURST_EN    = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_fcs,
   input  logic                          i_match,
   input  logic                          i_validspace,
   input  logic                          i_read,
   input  logic [3:0]                    i_ds_n,
   input  logic                          i_cbreq_n,
   input  logic [23:0]                   i_addr,
   input  logic [NUM_REGIONS*WAIT_W-1:0] i_region_wait,
   input  logic [NUM_REGIONS-1:0]        i_region_ready,
   output logic                          o_dtack,
   output logic                          o_cback,
   output logic                          o_berr,
   output logic [NUM_REGIONS-1:0]        o_region_sel,
   output logic [5:0]                    o_beat
);

   z3_state_t              r_state;
   logic                   r_dtack;
   logic                   r_cback;
   logic                   r_berr;
   logic [NUM_REGIONS-1:0] r_sel;
   logic [5:0]             r_beat;

   logic [NUM_REGIONS-1:0] w_hit;
   logic [NUM_REGIONS-1:0] w_first;
   logic [WAIT_W-1:0]      w_wait_val;
   logic                   w_ready;
   logic                   w_any_ds;
   logic                   w_go;
   logic                   w_load;
   logic                   w_run;
   logic                   w_wait_done;
   logic                   w_timed_out;
   logic                   w_cback_next;

   always_comb begin
      w_hit      = '0;
      w_first    = '0;
      w_wait_val = '0;
      for (int i = 0; i < NUM_REGIONS; i++)
         w_hit[i] = ((i_addr & REGION_MASK[i*24 +: 24])
                     == REGION_BASE[i*24 +: 24]);
      // Descending scan leaves the lowest-numbered hit selected.
      for (int i = NUM_REGIONS - 1; i >= 0; i--)
         if (w_hit[i]) begin
            w_first    = '0;
            w_first[i] = 1'b1;
         end
      for (int i = 0; i < NUM_REGIONS; i++)
         if (r_sel[i])
            w_wait_val = w_wait_val | i_region_wait[i*WAIT_W +: WAIT_W];
   end

   assign w_ready  = |(i_region_ready & r_sel);
   assign w_any_ds = ~&i_ds_n;
   assign w_go     = i_fcs & i_match & i_validspace & (|w_hit);
   assign w_run    = (r_state == Z3_DATA);
   assign w_load   = i_fcs &
                     (((r_state == Z3_START) & (i_read | w_any_ds)) |
                      ((r_state == Z3_NEXT) & w_any_ds));
   assign w_cback_next = BURST_EN & ~i_cbreq_n &
                         (i_addr[7:2] != Z3_LAST_LW);

   z3_wait_timer #(
      .WAIT_W  (WAIT_W),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_load      (w_load),
      .i_wait_val  (w_wait_val),
      .i_run       (w_run),
      .o_wait_done (w_wait_done),
      .o_timed_out (w_timed_out)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= Z3_IDLE;
         r_dtack <= 1'b0;
         r_cback <= 1'b0;
         r_berr  <= 1'b0;
         r_sel   <= '0;
         r_beat  <= '0;
      end else if (r_state != Z3_IDLE && !i_fcs) begin
         // Frame end outranks ready or timeout on the same edge.
         r_state <= Z3_IDLE;
         r_dtack <= 1'b0;
         r_cback <= 1'b0;
         r_berr  <= 1'b0;
         r_sel   <= '0;
         r_beat  <= '0;
      end else begin
         unique case (r_state)
            Z3_IDLE:
               if (w_go) begin
                  r_state <= Z3_START;
                  r_sel   <= w_first;
               end
            Z3_START:
               if (i_read || w_any_ds)
                  r_state <= Z3_DATA;
            Z3_DATA:
               if (w_wait_done && w_ready) begin
                  r_state <= Z3_END;
                  r_dtack <= 1'b1;
                  r_cback <= w_cback_next;
               end else if (w_timed_out) begin
                  r_state <= Z3_ERROR;
                  r_berr  <= 1'b1;
               end
            Z3_END:
               if (r_cback && !w_any_ds) begin
                  r_state <= Z3_NEXT;
                  r_dtack <= 1'b0;
                  r_beat  <= z3_beat_inc(r_beat);
               end
            Z3_NEXT:
               if (w_any_ds)
                  r_state <= Z3_DATA;
            Z3_ERROR:
               r_state <= Z3_ERROR;
            default:
               r_state <= Z3_IDLE;
         endcase
      end
   end

   assign o_dtack      = r_dtack;
   assign o_cback      = r_cback;
   assign o_berr       = r_berr;
   assign o_region_sel = r_sel;
   assign o_beat       = r_beat;

endmodule

// File: tb/tb_z3_slave_engine.sv
// Bench for z3_slave_engine: per-cycle timeline model built from
// latency rules, plus literal pins on key edges.
module tb_z3_slave_engine;

   localparam int NR   = 4;
   localparam int WW   = 4;
   localparam int TMO  = 63;
   localparam int MAXC = 2048;
   localparam logic [95:0] BASE =
      {24'h8C0000, 24'h880000, 24'h800000, 24'h000000};
   localparam logic [95:0] MASK =
      {24'hFC0000, 24'hFC0000, 24'hF80000, 24'h800000};

   logic           clk = 1'b0;
   logic           reset;
   logic           fcs;
   logic           match;
   logic           validspace;
   logic           read;
   logic [3:0]     ds_n;
   logic           cbreq_n;
   logic [23:0]    addr;
   logic [NR*WW-1:0] region_wait;
   logic [NR-1:0]  region_ready;
   logic           dtack;
   logic           cback;
   logic           berr;
   logic [NR-1:0]  region_sel;
   logic [5:0]     beat;

   always #5 clk = ~clk;

   z3_slave_engine #(
      .NUM_REGIONS (NR),
      .REGION_BASE (BASE),
      .REGION_MASK (MASK),
      .WAIT_W      (WW),
      .TIMEOUT     (TMO),
      .BURST_EN    (1'b1)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_fcs          (fcs),
      .i_match        (match),
      .i_validspace   (validspace),
      .i_read         (read),
      .i_ds_n         (ds_n),
      .i_cbreq_n      (cbreq_n),
      .i_addr         (addr),
      .i_region_wait  (region_wait),
      .i_region_ready (region_ready),
      .o_dtack        (dtack),
      .o_cback        (cback),
      .o_berr         (berr),
      .o_region_sel   (region_sel),
      .o_beat         (beat)
   );

   typedef struct {
      int dt;
      int cb;
      int be;
      int sel;
      int bt;
   } exp_t;

   typedef struct {
      int    at;
      string nm;
      int    sig;
      int    val;
   } pin_t;

   exp_t exp_tl [MAXC];
   pin_t pins [$];
   int   pins_hit = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   c0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int want);
      n_chk++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d",
                  nm, cyc, act, want);
      end
   endtask

   function automatic int sigval(input int s);
      case (s)
         0: return int'(dtack);
         1: return int'(cback);
         2: return int'(berr);
         3: return int'(region_sel);
         default: return int'(beat);
      endcase
   endfunction

   function automatic logic [3:0] lowest_hit(input logic [23:0] a);
      logic [23:0] b;
      logic [23:0] m;
      for (int i = 0; i < NR; i++) begin
         b = BASE[i*24 +: 24];
         m = MASK[i*24 +: 24];
         if ((a & m) == b) return 4'(1 << i);
      end
      return 4'b0000;
   endfunction

   function automatic int sat(input int x);
      return (x > 63) ? 63 : x;
   endfunction

   task automatic set_exp(input int f, input int t, input int dt,
                          input int cb, input int be, input int sel,
                          input int bt);
      for (int k = f; k <= t; k++)
         if (k >= 0 && k < MAXC) begin
            exp_tl[k].dt  = dt;
            exp_tl[k].cb  = cb;
            exp_tl[k].be  = be;
            exp_tl[k].sel = sel;
            exp_tl[k].bt  = bt;
         end
   endtask

   task automatic pin(input int at, input string nm, input int sig,
                      input int val);
      pins.push_back('{at, nm, sig, val});
   endtask

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC) begin
         chk("dtack", int'(dtack), exp_tl[cyc].dt);
         chk("cback", int'(cback), exp_tl[cyc].cb);
         chk("berr", int'(berr), exp_tl[cyc].be);
         chk("region_sel", int'(region_sel), exp_tl[cyc].sel);
         chk("beat", int'(beat), exp_tl[cyc].bt);
         foreach (pins[i])
            if (pins[i].at == cyc) begin
               chk(pins[i].nm, sigval(pins[i].sig), pins[i].val);
               pins_hit++;
            end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_on(input logic [23:0] a);
      addr       = a;
      fcs        = 1'b1;
      match      = 1'b1;
      validspace = 1'b1;
   endtask

   task automatic frame_off();
      fcs     = 1'b0;
      read    = 1'b0;
      ds_n    = 4'hF;
      cbreq_n = 1'b1;
   endtask

   // Single transfer: DTACK after edge 3+W, held `hold` cycles;
   // hold < 0 drops FCS on the edge DTACK would have come.
   task automatic single(input logic [23:0] a, input logic rd,
                         input int w, input int hold, input bit chg);
      int s;
      int de;
      int last;
      int st;
      st = cyc;
      s  = int'(lowest_hit(a));
      de = st + 3 + w;
      if (s == 0) begin
         last = st + 6;
      end else if (hold < 0) begin
         last = de - 1;
         set_exp(st + 1, last, 0, 0, 0, s, 0);
      end else begin
         last = de + hold;
         set_exp(st + 1, de - 1, 0, 0, 0, s, 0);
         set_exp(de, last, 1, 0, 0, s, 0);
      end
      region_wait  = {NR{WW'(w)}};
      region_ready = '1;
      read         = rd;
      ds_n         = rd ? 4'hF : 4'h0;
      cbreq_n      = 1'b1;
      frame_on(a);
      while (cyc < last) begin
         tick();
         if (chg && cyc == st + 3) region_wait = '0;
      end
      frame_off();
      tick();
      tick();
   endtask

   // Burst of up to nb beats; the expected timeline is laid out
   // first from beat spacing 3+W and the CBACK rules.
   task automatic burst(input logic [23:0] a0, input int nb,
                        input int w, input int incr);
      int s;
      int e;
      int b;
      int cbv;
      bit done;
      logic [23:0] a;
      int ends [$];
      int cbs [$];
      int st;
      st   = cyc;
      s    = int'(lowest_hit(a0));
      set_exp(st + 1, st + 2 + w, 0, 0, 0, s, 0);
      e    = st + 3 + w;
      b    = 0;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         a   = a0 + 24'(4 * b * incr);
         cbv = (b < nb - 1 && a[7:2] != 6'h3F) ? 1 : 0;
         ends.push_back(e);
         cbs.push_back(cbv);
         set_exp(e, e, 1, cbv, 0, s, sat(b));
         if (cbv != 0) begin
            set_exp(e + 1, e + 2 + w, 0, 1, 0, s, sat(b + 1));
            e = e + 3 + w;
            b++;
         end else begin
            set_exp(e + 1, e + 1, 1, 0, 0, s, sat(b));
            done = 1'b1;
         end
      end
      region_wait  = {NR{WW'(w)}};
      region_ready = '1;
      read         = 1'b0;
      ds_n         = 4'h0;
      cbreq_n      = (nb > 1) ? 1'b0 : 1'b1;
      frame_on(a0);
      for (int k = 0; k < ends.size(); k++) begin
         while (cyc < ends[k]) tick();
         ds_n = 4'hF;
         tick();
         if (cbs[k] != 0) begin
            addr    = a0 + 24'(4 * (k + 1) * incr);
            cbreq_n = (k + 1 < nb - 1) ? 1'b0 : 1'b1;
            ds_n    = 4'h0;
         end else begin
            frame_off();
            tick();
            tick();
         end
      end
   endtask

   // Read whose device raises ready at st+rdy_rel (never if < 0).
   task automatic tmo(input logic [23:0] a, input int rdy_rel);
      int s;
      int ev;
      int dt;
      int last;
      int st;
      st = cyc;
      s  = int'(lowest_hit(a));
      if (rdy_rel >= 0 && rdy_rel + 1 <= 2 + TMO) begin
         ev = st + ((rdy_rel + 1 > 3) ? rdy_rel + 1 : 3);
         dt = 1;
      end else begin
         ev = st + 2 + TMO;
         dt = 0;
      end
      last = ev + 2;
      set_exp(st + 1, ev - 1, 0, 0, 0, s, 0);
      set_exp(ev, last, dt, 0, 1 - dt, s, 0);
      region_wait  = '0;
      region_ready = '0;
      read         = 1'b1;
      ds_n         = 4'hF;
      cbreq_n      = 1'b1;
      frame_on(a);
      while (cyc < last) begin
         if (cyc == st + rdy_rel) region_ready = '1;
         tick();
      end
      frame_off();
      tick();
      region_ready = '1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < MAXC; k++) set_exp(k, k, 0, 0, 0, 0, 0);
      reset        = 1'b1;
      fcs          = 1'b0;
      match        = 1'b0;
      validspace   = 1'b0;
      read         = 1'b0;
      ds_n         = 4'hF;
      cbreq_n      = 1'b1;
      addr         = '0;
      region_wait  = '0;
      region_ready = '1;
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();

      c0 = cyc;
      pin(c0 + 2, "t1_dtack_e2", 0, 0);
      pin(c0 + 3, "t1_dtack_e3", 0, 1);
      pin(c0 + 3, "t1_sel", 3, 4);
      pin(c0 + 6, "t1_dtack_drop", 0, 0);
      single(24'h880010, 1'b1, 0, 2, 1'b0);

      c0 = cyc;
      pin(c0 + 7, "t2_dtack_e7", 0, 0);
      pin(c0 + 8, "t2_dtack_e8", 0, 1);
      pin(c0 + 8, "t2_cback", 1, 0);
      pin(c0 + 8, "t2_sel", 3, 1);
      single(24'h000100, 1'b0, 5, 1, 1'b1);

      c0 = cyc;
      pin(c0 + 3, "t3_cback_b0", 1, 1);
      pin(c0 + 9, "t3_cback_b2", 1, 1);
      pin(c0 + 12, "t3_dtack_b3", 0, 1);
      pin(c0 + 12, "t3_cback_3f", 1, 0);
      pin(c0 + 12, "t3_beat", 4, 3);
      burst(24'h0000F0, 4, 0, 1);

      c0 = cyc;
      pin(c0 + 5, "t3b_beat_next", 4, 1);
      pin(c0 + 8, "t3b_dtack_3f", 0, 1);
      pin(c0 + 8, "t3b_cback_3f", 1, 0);
      burst(24'h0000F8, 5, 1, 1);

      c0 = cyc;
      pin(c0 + 189, "sat_beat62", 4, 62);
      pin(c0 + 195, "sat_beat64", 4, 63);
      pin(c0 + 198, "sat_beat65", 4, 63);
      burst(24'h000000, 66, 0, 0);

      c0 = cyc;
      pin(c0 + 64, "t4_berr_e64", 2, 0);
      pin(c0 + 65, "t4_berr_e65", 2, 1);
      pin(c0 + 65, "t4_dtack", 0, 0);
      pin(c0 + 68, "t4_berr_drop", 2, 0);
      tmo(24'h880010, -1);

      c0 = cyc;
      pin(c0 + 65, "t4b_dtack", 0, 1);
      pin(c0 + 65, "t4b_berr", 2, 0);
      tmo(24'h8C0004, TMO + 1);

      c0 = cyc;
      pin(c0 + 5, "abort_dtack", 0, 0);
      single(24'h880020, 1'b1, 2, -1, 1'b0);

      c0 = cyc;
      pin(c0 + 3, "nohit_sel", 3, 0);
      pin(c0 + 3, "nohit_dtack", 0, 0);
      single(24'h900000, 1'b1, 0, 2, 1'b0);

      c0 = cyc;
      pin(c0 + 3, "rst_cback_before", 1, 1);
      pin(c0 + 4, "rst_cback", 1, 0);
      pin(c0 + 4, "rst_dtack", 0, 0);
      pin(c0 + 4, "rst_sel", 3, 0);
      set_exp(c0 + 1, c0 + 2, 0, 0, 0, 1, 0);
      set_exp(c0 + 3, c0 + 3, 1, 1, 0, 1, 0);
      region_wait  = '0;
      region_ready = '1;
      read         = 1'b0;
      ds_n         = 4'h0;
      cbreq_n      = 1'b0;
      frame_on(24'h000010);
      while (cyc < c0 + 3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      frame_off();
      tick();
      tick();

      c0 = cyc;
      pin(c0 + 4, "fresh_dtack", 0, 1);
      single(24'h000200, 1'b1, 1, 1, 1'b0);

      tick();
      tick();
      chk("pins_reached", pins_hit, pins.size());
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
